// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - end-of-test store signature checker with store trace FIFO
// Watches the data-memory write bus, flags PASS on a signature store or FAIL on timeout.
module store_monitor #(
  parameter logic [63:0] SIG0_ADDR = 64'd84,
  parameter logic [63:0] SIG0_DATA = 64'd7,
  parameter logic [63:0] SIG1_ADDR = 64'd128,
  parameter logic [63:0] SIG1_DATA = 64'd7,
  parameter logic [63:0] SIG2_ADDR = 64'd80,
  parameter logic [63:0] SIG2_DATA = 64'd1,
  parameter int          TIMEOUT   = 512,
  parameter int          LOG_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [1:0]                   i_memwrite,
  input  logic [63:0]                  i_dataadr,
  input  logic [63:0]                  i_writedata,
  output logic                         o_pass,
  output logic                         o_fail,
  output logic                         o_halt,
  output logic [1:0]                   o_pass_id,
  output logic [15:0]                  o_store_count,
  output logic                         o_log_valid,
  input  logic                         i_log_ready,
  output logic [1:0]                   o_log_mode,
  output logic [63:0]                  o_log_addr,
  output logic [63:0]                  o_log_data,
  output logic [$clog2(LOG_DEPTH):0]   o_log_count,
  output logic                         o_log_overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(LOG_DEPTH);
  localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_pass_id, w_pass_id_nxt;
  logic [CW-1:0] r_cycles;
  logic [15:0]   r_store_count;
  logic          r_overflow;

  logic [1:0]    r_mode [LOG_DEPTH];
  logic [63:0]   r_addr [LOG_DEPTH];
  logic [63:0]   r_data [LOG_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;

  logic w_run, w_store, w_hit0, w_hit1, w_hit2, w_match, w_timeout;
  logic w_full, w_push, w_pop, w_drop;

  assign w_run     = (r_state == S_RUN);
  assign w_store   = w_run && (i_memwrite != 2'b00);
  assign w_hit0    = w_store && (i_dataadr == SIG0_ADDR) && (i_writedata == SIG0_DATA);
  assign w_hit1    = w_store && (i_dataadr == SIG1_ADDR) && (i_writedata == SIG1_DATA);
  assign w_hit2    = w_store && (i_dataadr == SIG2_ADDR) && (i_writedata == SIG2_DATA);
  assign w_match   = w_hit0 || w_hit1 || w_hit2;
  assign w_timeout = (r_cycles == LAST_CYC);

  // A store arriving on a full FIFO still lands if the head leaves the same cycle.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && i_log_ready;
  assign w_push = w_store && (!w_full || w_pop);
  assign w_drop = w_store && w_full && !w_pop;

  always_comb begin
    w_state_nxt   = r_state;
    w_pass_id_nxt = r_pass_id;
    case (r_state)
      S_RUN: begin
        if (w_match) begin
          w_state_nxt   = S_PASS;
          w_pass_id_nxt = w_hit0 ? 2'd0 : (w_hit1 ? 2'd1 : 2'd2);
        end else if (w_timeout) begin
          w_state_nxt = S_FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_RUN;
      r_pass_id     <= 2'd3;
      r_cycles      <= '0;
      r_store_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pass_id <= w_pass_id_nxt;
      if (w_run)
        r_cycles <= r_cycles + CW'(1);
      if (w_store && (r_store_count != 16'hFFFF))
        r_store_count <= r_store_count + 16'd1;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_mode[r_wr_ptr] <= i_memwrite;
      r_addr[r_wr_ptr] <= i_dataadr;
      r_data[r_wr_ptr] <= i_writedata;
    end
  end

  assign o_pass         = (r_state == S_PASS);
  assign o_fail         = (r_state == S_FAIL);
  assign o_halt         = o_pass || o_fail;
  assign o_pass_id      = r_pass_id;
  assign o_store_count  = r_store_count;
  assign o_log_valid    = (r_count != '0);
  assign o_log_mode     = r_mode[r_rd_ptr];
  assign o_log_addr     = r_addr[r_rd_ptr];
  assign o_log_data     = r_data[r_rd_ptr];
  assign o_log_count    = r_count;
  assign o_log_overflow = r_overflow;

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - scoreboard bench for store_monitor
// Directed test-plan scenarios followed by randomized runs against a behavioural model.
module tb_store_monitor;

  localparam int TIMEOUT = 512;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_memwrite = '0;
  logic [63:0] i_dataadr = '0, i_writedata = '0;
  logic        i_log_ready = 1'b0;
  logic        o_pass, o_fail, o_halt, o_log_valid, o_log_overflow;
  logic [1:0]  o_pass_id, o_log_mode;
  logic [15:0] o_store_count;
  logic [63:0] o_log_addr, o_log_data;
  logic [3:0]  o_log_count;

  store_monitor dut (
    .i_clk(clk), .i_reset(i_reset), .i_memwrite(i_memwrite), .i_dataadr(i_dataadr),
    .i_writedata(i_writedata), .o_pass(o_pass), .o_fail(o_fail), .o_halt(o_halt),
    .o_pass_id(o_pass_id), .o_store_count(o_store_count), .o_log_valid(o_log_valid),
    .i_log_ready(i_log_ready), .o_log_mode(o_log_mode), .o_log_addr(o_log_addr),
    .o_log_data(o_log_data), .o_log_count(o_log_count), .o_log_overflow(o_log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [63:0] sig_a[3];
  logic [63:0] sig_d[3];

  int m_pass, m_fail, m_id, m_cycles, m_stores, m_count, m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DUT pop must present the oldest accepted store.
  always @(negedge clk) begin
    if (!i_reset && o_log_valid && i_log_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'd1, 64'd0);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("log_mode", {62'd0, o_log_mode}, {62'd0, e.m});
        chk("log_addr", o_log_addr, e.a);
        chk("log_data", o_log_data, e.d);
      end
    end
  end

  task automatic predict();
    int  hit;
    bit  running, pop;
    if (i_reset) begin
      m_pass = 0; m_fail = 0; m_id = 3; m_cycles = 0;
      m_stores = 0; m_count = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      hit     = -1;
      running = (m_pass == 0) && (m_fail == 0);
      pop     = (m_count > 0) && i_log_ready;
      if (running && i_memwrite != 2'b00) begin
        for (int k = 0; k < 3; k++)
          if (hit < 0 && i_dataadr == sig_a[k] && i_writedata == sig_d[k]) hit = k;
        if (m_stores < 65535) m_stores++;
        if (m_count < DEPTH || pop) begin
          ent_t e;
          e.m = i_memwrite; e.a = i_dataadr; e.d = i_writedata;
          exp_q.push_back(e);
          m_count++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_count--;
      if (running) begin
        m_cycles++;
        if (hit >= 0) begin
          m_pass = 1; m_id = hit;
        end else if (m_cycles == TIMEOUT) begin
          m_fail = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("pass", {63'd0, o_pass}, 64'(m_pass));
    chk("fail", {63'd0, o_fail}, 64'(m_fail));
    chk("halt", {63'd0, o_halt}, 64'(m_pass | m_fail));
    chk("pass_id", {62'd0, o_pass_id}, 64'(m_id));
    chk("store_count", {48'd0, o_store_count}, 64'(m_stores));
    chk("log_count", {60'd0, o_log_count}, 64'(m_count));
    chk("log_valid", {63'd0, o_log_valid}, 64'(m_count > 0));
    chk("log_overflow", {63'd0, o_log_overflow}, 64'(m_ovf));
  endtask

  task automatic cyc(input logic rst, input logic [1:0] mw, input logic [63:0] a,
                     input logic [63:0] d, input logic rdy);
    i_reset = rst; i_memwrite = mw; i_dataadr = a; i_writedata = d; i_log_ready = rdy;
    predict();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 64'd0, 64'd0, rdy);
  endtask

  initial begin
    logic [63:0] pool[6];
    logic [63:0] dpool[3];
    sig_a[0] = 64'd84;  sig_d[0] = 64'd7;
    sig_a[1] = 64'd128; sig_d[1] = 64'd7;
    sig_a[2] = 64'd80;  sig_d[2] = 64'd1;
    pool[0] = 64'd0; pool[1] = 64'd8; pool[2] = 64'd80;
    pool[3] = 64'd84; pool[4] = 64'd128; pool[5] = 64'd16;
    dpool[0] = 64'd1; dpool[1] = 64'd3; dpool[2] = 64'd7;

    // Timeout with no stores
    for (int k = 0; k < 3; k++) cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    chk("reset_pass_id", {62'd0, o_pass_id}, 64'd3);
    chk("reset_log_count", {60'd0, o_log_count}, 64'd0);
    idle(511, 1'b0);
    chk("fail_before_timeout", {63'd0, o_fail}, 64'd0);
    idle(1, 1'b0);
    chk("fail_at_timeout", {63'd0, o_fail}, 64'd1);
    chk("halt_at_timeout", {63'd0, o_halt}, 64'd1);
    chk("pass_id_after_fail", {62'd0, o_pass_id}, 64'd3);

    // Signature 0 on second store, later store ignored
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    cyc(1'b0, 2'b01, 64'd8, 64'd3, 1'b0);
    cyc(1'b0, 2'b01, 64'd84, 64'd7, 1'b0);
    chk("sig0_pass", {63'd0, o_pass}, 64'd1);
    chk("sig0_id", {62'd0, o_pass_id}, 64'd0);
    chk("sig0_store_count", {48'd0, o_store_count}, 64'd2);
    cyc(1'b0, 2'b01, 64'd128, 64'd7, 1'b0);
    chk("post_pass_log_count", {60'd0, o_log_count}, 64'd2);
    idle(4, 1'b1);

    // Match on the timeout cycle wins
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    idle(511, 1'b0);
    cyc(1'b0, 2'b11, 64'd128, 64'd7, 1'b0);
    chk("edge_pass", {63'd0, o_pass}, 64'd1);
    chk("edge_id", {62'd0, o_pass_id}, 64'd1);
    chk("edge_fail", {63'd0, o_fail}, 64'd0);
    idle(2, 1'b1);

    // Signature 2
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    cyc(1'b0, 2'b10, 64'd80, 64'd1, 1'b0);
    chk("sig2_id", {62'd0, o_pass_id}, 64'd2);

    // Overflow then in-order drain
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 2'b01, 64'(k), 64'(100 + k), 1'b0);
    chk("ovf_count", {60'd0, o_log_count}, 64'd8);
    chk("ovf_flag", {63'd0, o_log_overflow}, 64'd1);
    chk("ovf_head_addr", o_log_addr, 64'd0);
    idle(9, 1'b1);
    chk("drained_valid", {63'd0, o_log_valid}, 64'd0);

    // Push and pop on a full FIFO
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 2'b01, 64'(16 + k), 64'(200 + k), 1'b0);
    cyc(1'b0, 2'b10, 64'd300, 64'd55, 1'b1);
    chk("full_pp_count", {60'd0, o_log_count}, 64'd8);
    chk("full_pp_ovf", {63'd0, o_log_overflow}, 64'd0);
    idle(9, 1'b1);

    // Reset after PASS
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    cyc(1'b0, 2'b01, 64'd8, 64'd9, 1'b0);
    cyc(1'b0, 2'b01, 64'd16, 64'd9, 1'b0);
    cyc(1'b0, 2'b01, 64'd84, 64'd7, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
    chk("rst_pass", {63'd0, o_pass}, 64'd0);
    chk("rst_halt", {63'd0, o_halt}, 64'd0);
    chk("rst_pass_id", {62'd0, o_pass_id}, 64'd3);
    chk("rst_log_count", {60'd0, o_log_count}, 64'd0);
    chk("rst_store_count", {48'd0, o_store_count}, 64'd0);
    idle(3, 1'b0);

    // Randomized runs; odd runs never hit a signature and must time out
    for (int r = 0; r < 6; r++) begin
      cyc(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);
      for (int k = 0; k < 560; k++) begin
        logic [1:0]  mw;
        logic [63:0] a, d;
        mw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (r % 2 == 1) a = 64'd256 + 64'($urandom_range(0, 63));
        else            a = pool[$urandom_range(0, 5)];
        d = dpool[$urandom_range(0, 2)];
        cyc(1'b0, mw, a, d, 1'($urandom_range(0, 1)));
      end
      if (r % 2 == 1) chk("rand_timeout", {63'd0, o_fail}, 64'd1);
    end

    idle(DEPTH + 2, 1'b1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
